// File: rtl/modn_updown_counter.sv
// ---------------------------------------------------------------------------
// modn_updown_counter
//
// Parametrised synchronous up/down modulo-N counter with parallel load,
// count enable, a combinational terminal-count flag and a registered wrap
// pulse. It is meant to be cascaded into multi-digit counters (BCD digits,
// timers): drive the next stage's en from this stage's tc.
//
// Parameters
//   WIDTH    bit width of the count register (>= 1)
//   MODULUS  number of count states, count runs 0..MODULUS-1
//            (2 <= MODULUS <= 2**WIDTH)
//
// Ports
//   clk     in   1      rising-edge clock
//   rst     in   1      synchronous active-high reset
//   en      in   1      count enable
//   up      in   1      direction, 1 = up, 0 = down
//   load    in   1      synchronous parallel load strobe
//   d       in   WIDTH  parallel load value (out-of-range values load 0)
//   q       out  WIDTH  current count, registered
//   q_gray  out  WIDTH  Gray-code form of q, registered alongside q
//   tc      out  1      terminal count, high in the cycle before a wrap edge
//   wrap    out  1      one-cycle pulse in the cycle after a wrap edge
//
// Edge priority is rst > load > en.
// ---------------------------------------------------------------------------
module modn_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_gray,
    output logic             tc,
    output logic             wrap
);

    // Highest legal count, and the modulus widened by one bit so that
    // MODULUS == 2**WIDTH is still representable for range comparisons.
    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULUS);

    // Reject illegal parameter combinations while the design elaborates.
    if (WIDTH < 1 || MODULUS < 2 || ((MODULUS - 1) >> WIDTH) != 0) begin : g_bad_params
        $error("modn_updown_counter: MODULUS=%0d illegal for WIDTH=%0d", MODULUS, WIDTH);
    end

    logic [WIDTH-1:0] q_next;
    logic             wrap_next;
    logic             d_in_range;
    logic             q_in_range;

    assign d_in_range = ({1'b0, d} < MOD_EXT);
    assign q_in_range = ({1'b0, q} < MOD_EXT);

    // Next-count selection for load / count / hold. Reset is applied in the
    // register process because it overrides everything here. A count edge
    // from an out-of-range value (only reachable after a glitch) recovers
    // to 0 in either direction and does not count as a wrap.
    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        if (load) begin
            q_next = d_in_range ? d : '0;
        end else if (en) begin
            if (!q_in_range) begin
                q_next = '0;
            end else if (up) begin
                if (q == MAX_COUNT) begin
                    q_next    = '0;
                    wrap_next = 1'b1;
                end else begin
                    q_next = q + 1'b1;
                end
            end else begin
                if (q == '0) begin
                    q_next    = MAX_COUNT;
                    wrap_next = 1'b1;
                end else begin
                    q_next = q - 1'b1;
                end
            end
        end
    end

    // Count, Gray and wrap registers. The Gray value is encoded from the
    // next count so that q_gray always matches the q it is registered with.
    always_ff @(posedge clk) begin
        if (rst) begin
            q      <= '0;
            q_gray <= '0;
            wrap   <= 1'b0;
        end else begin
            q      <= q_next;
            q_gray <= q_next ^ (q_next >> 1);
            wrap   <= wrap_next;
        end
    end

    // Terminal count is combinational so a cascaded stage sees it in the
    // same cycle and steps on exactly the edge where this stage wraps.
    assign tc = en & ~load & ~rst &
                ((up & (q == MAX_COUNT)) | (~up & (q == '0)));

endmodule

// File: tb/tb_modn_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_modn_updown_counter
//
// Self-checking bench for modn_updown_counter. A decimal (WIDTH=4,
// MODULUS=10) instance is driven through directed steps; a behavioural
// model pushes the expected registered outputs into a scoreboard queue when
// each step is driven, and they are popped and compared after the edge.
// A MODULUS=16 instance exercises the Gray output and a two-stage decimal
// cascade checks tc-driven chaining.
// ---------------------------------------------------------------------------
module tb_modn_updown_counter;

    localparam int W = 4;
    localparam int M = 10;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] g;
        logic         wrap;
        string        tag;
    } exp_t;

    // Free-running clock, 10 time units per cycle.
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main decimal counter.
    logic         rst, en, up, load;
    logic [W-1:0] d;
    logic [W-1:0] q, q_gray;
    logic         tc, wrap;

    modn_updown_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
        .q(q), .q_gray(q_gray), .tc(tc), .wrap(wrap)
    );

    // Full-range instance for the Gray sequence.
    logic         rst16, en16, up16, load16;
    logic [W-1:0] d16, q16, g16;
    logic         tc16, wrap16;

    modn_updown_counter #(.WIDTH(W), .MODULUS(16)) dut16 (
        .clk(clk), .rst(rst16), .en(en16), .up(up16), .load(load16), .d(d16),
        .q(q16), .q_gray(g16), .tc(tc16), .wrap(wrap16)
    );

    // Two-digit decimal cascade: stage 2 is enabled by stage 1's tc.
    logic         crst, one, zero;
    logic [W-1:0] dzero, q1, g1, q2, g2;
    logic         tc1, w1, tc2, w2;

    modn_updown_counter #(.WIDTH(W), .MODULUS(M)) stage1 (
        .clk(clk), .rst(crst), .en(one), .up(one), .load(zero), .d(dzero),
        .q(q1), .q_gray(g1), .tc(tc1), .wrap(w1)
    );

    modn_updown_counter #(.WIDTH(W), .MODULUS(M)) stage2 (
        .clk(clk), .rst(crst), .en(tc1), .up(one), .load(zero), .d(dzero),
        .q(q2), .q_gray(g2), .tc(tc2), .wrap(w2)
    );

    exp_t sb[$];
    int   testsRun  = 0;
    int   failCount = 0;
    int   mq        = 0;

    // Single comparison point: counts the test and reports any miss.
    task automatic compareVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one step, check tc against the model, and queue the expected
    // registered outputs for the coming edge.
    task automatic applyStimulus(input logic r, input logic l, input logic e,
                                 input logic u, input logic [W-1:0] dv,
                                 input string tag);
        exp_t x;
        int   nq;
        logic nw;
        logic etc;
        rst = r; load = l; en = e; up = u; d = dv;
        #1;
        etc = e & ~l & ~r & ((u & (mq == M - 1)) | (~u & (mq == 0)));
        compareVal({tag, " tc"}, {31'b0, tc}, {31'b0, etc});
        nw = 1'b0;
        if (r)           nq = 0;
        else if (l)      nq = (int'(dv) < M) ? int'(dv) : 0;
        else if (e && u) begin nq = (mq == M - 1) ? 0 : mq + 1; nw = (mq == M - 1); end
        else if (e)      begin nq = (mq == 0) ? M - 1 : mq - 1; nw = (mq == 0); end
        else             nq = mq;
        x.q    = W'(nq);
        x.g    = x.q ^ (x.q >> 1);
        x.wrap = nw;
        x.tag  = tag;
        sb.push_back(x);
        mq = nq;
    endtask

    // Wait for the edge, then pop the oldest expectation and compare.
    task automatic checkOutput();
        exp_t x;
        @(posedge clk);
        #1;
        x = sb.pop_front();
        compareVal({x.tag, " q"},    {28'b0, q},      {28'b0, x.q});
        compareVal({x.tag, " gray"}, {28'b0, q_gray}, {28'b0, x.g});
        compareVal({x.tag, " wrap"}, {31'b0, wrap},   {31'b0, x.wrap});
    endtask

    task automatic step(input logic r, input logic l, input logic e,
                        input logic u, input logic [W-1:0] dv, input string tag);
        applyStimulus(r, l, e, u, dv, tag);
        checkOutput();
    endtask

    logic [W-1:0] prevG, expQ;

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; d = '0;
        rst16 = 1'b1; en16 = 1'b0; up16 = 1'b1; load16 = 1'b0; d16 = '0;
        crst = 1'b1; one = 1'b1; zero = 1'b0; dzero = '0;
        @(posedge clk);
        #1;

        // Reset then count up through the 9 -> 0 wrap.
        step(1, 0, 0, 1, 0, "reset0");
        step(1, 0, 0, 1, 0, "reset1");
        for (int i = 0; i < 12; i++) step(0, 0, 1, 1, 0, "countUp");
        compareVal("countUp final", {28'b0, q}, 32'd2);

        // Load 2 and count down through the 0 -> 9 wrap.
        step(0, 1, 0, 1, 4'd2, "load2");
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, "countDown");
        compareVal("countDown final", {28'b0, q}, 32'd7);

        // Load beats enable, out-of-range load clears, reset beats load.
        step(0, 1, 1, 1, 4'd7, "loadOverEn");
        compareVal("loadOverEn const", {28'b0, q}, 32'd7);
        step(0, 1, 1, 0, 4'd12, "loadOutOfRange");
        step(0, 1, 0, 1, 4'd15, "loadMax");
        compareVal("loadMax const", {28'b0, q}, 32'd0);
        step(1, 1, 1, 1, 4'd5, "resetOverLoad");

        // Count to 4, hold three cycles, then reverse direction.
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0, "upTo4");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, "hold");
        compareVal("hold const", {28'b0, q}, 32'd4);
        step(0, 0, 1, 0, 0, "flipDown");
        step(0, 0, 1, 0, 0, "flipDown");
        compareVal("flipDown const", {28'b0, q}, 32'd2);
        en = 1'b0; load = 1'b0; rst = 1'b0;

        // Gray sequence over the full 4-bit range, including 15 -> 0.
        @(posedge clk);
        #1;
        compareVal("gray reset q", {28'b0, q16}, 32'd0);
        compareVal("gray reset g", {28'b0, g16}, 32'd0);
        rst16 = 1'b0; en16 = 1'b1;
        prevG = g16;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            expQ = W'(i % 16);
            compareVal("gray q", {28'b0, q16}, {28'b0, expQ});
            compareVal("gray code", {28'b0, g16}, {28'b0, expQ ^ (expQ >> 1)});
            compareVal("gray onebit", $countones(g16 ^ prevG), 32'd1);
            compareVal("gray wrap", {31'b0, wrap16}, (i == 16) ? 32'd1 : 32'd0);
            prevG = g16;
        end
        en16 = 1'b0;

        // Two-stage cascade counts 25 from reset.
        crst = 1'b1;
        @(posedge clk);
        #1;
        crst = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk);
            #1;
            compareVal("cascade q1", {28'b0, q1}, k % 10);
            compareVal("cascade q2", {28'b0, q2}, k / 10);
        end
        compareVal("cascade total", {24'b0, q2, q1}, 32'h25);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/modn_updown_counter.md
Name: modn_updown_counter

Overview:
- Parametrised synchronous up/down modulo-N counter.
- Generalises the fixed 2-bit free-running counter in four ways: configurable width and modulus, count direction, count enable, and parallel load.
- Provides a terminal-count flag and a registered wrap pulse, so instances can be cascaded into multi-digit counters such as BCD digits or timers.
- Sits in the sequential-circuits library beside the existing flip-flop and counter blocks.

Parameters:
- WIDTH, 4, bit width of the count register; must be at least 1.
- MODULUS, 10, number of count states; the count runs 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = count up, 0 = count down.
- load  input  1  synchronous parallel load strobe.
- d  input  WIDTH  parallel load value.
- q  output  WIDTH  current count, registered.
- q_gray  output  WIDTH  Gray-code form of q, registered and updated in the same cycle as q.
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high and is sampled only on the rising edge of clk.
- Reset values: q = 0, q_gray = 0, wrap = 0. tc is combinational and follows its own equation while reset is held.
- Priority at each rising edge: rst > load > en. Lower-priority inputs are ignored in any cycle where a higher-priority input is active.
- Load, load=1:
  - If d < MODULUS, q <= d.
  - If d >= MODULUS, q <= 0.
  - wrap <= 0.
  - Load works regardless of en and up.
- Counting, en=1 and load=0:
  - Up, up=1: q <= q+1. When q == MODULUS-1, q <= 0 instead.
  - Down, up=0: q <= q-1. When q == 0, q <= MODULUS-1 instead.
- Hold, en=0 and load=0: q holds its value and wrap <= 0.
- wrap: wrap <= 1 exactly when the edge takes a wrap transition (MODULUS-1 -> 0 going up, or 0 -> MODULUS-1 going down). Otherwise wrap <= 0. It is high for the single cycle after the wrap edge.
- tc = en & ~load & ~rst & ((up & q == MODULUS-1) | (~up & q == 0)).
  - tc is high in the cycle before a wrap edge.
  - It is intended to drive the en of the next cascaded stage.
- q_gray: registered encoding of the next q, computed as next ^ (next >> 1). It therefore always equals q ^ (q >> 1) of the current q.
- Latency: q changes on the edge at which the controls are sampled, one-cycle latency. tc has zero latency from q, en and up.
- Illegal states: if q ever holds a value >= MODULUS (only possible when MODULUS < 2**WIDTH, e.g. after an X-propagation glitch), the next enabled count edge forces q <= 0 in either direction.
- Direction changes mid-count are legal and take effect on the same edge; there is no turnaround delay.
- Reset mid-count: a reset asserted for one cycle returns q to 0 on that edge. Counting resumes from 0 on the next edge with en=1.
- MODULUS == 2**WIDTH: the count wraps naturally. The out-of-range clamp is never taken.
- Assertion: a parameter check flags MODULUS outside its legal range at elaboration or time 0.

Test Plan:
1. Reset and count up: rst=1 for 2 cycles, then en=1, up=1 for 12 cycles -> q runs 0,1,...,9,0,1; tc=1 only while q=9; wrap=1 only in the cycle where q=0 after the 9.
2. Count down with wrap: load d=2, then en=1, up=0 -> q runs 2,1,0,9,8; tc=1 while q=0; wrap pulses once, coincident with q=9.
3. Load priority and out-of-range load: en=1 with load=1, d=7 -> q=7. Then load=1, d=12 -> q=0. Then rst=1 together with load=1, d=5 -> q=0.
4. Enable hold and mid-count direction flip: count up to 4, deassert en for 3 cycles -> q stays 4 and tc=0. Set en=1, up=0 -> q runs 3,2.
5. Gray output: with WIDTH=4 and MODULUS=16, count 0..15 -> q_gray runs 0000,0001,0011,0010,...,1000; exactly one bit changes per step, including the step 15 -> 0.
6. Cascade: two instances, where stage 1 has en tied to 1, up=1, and stage 2 has en driven by stage 1's tc; count 25 cycles from reset -> {q2,q1} = 2,5 (decimal 25). Stage 2 steps exactly once per stage-1 wrap.
